seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Per-digit hex decoding, decimal points and per-digit blanking, with a tear-free load that applies new data at frame boundaries.
- Sits between datapath/debug registers and the board display pins.

---
 rtl/seg7_scan_driver.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit common-anode seven-segment driver
//
// Scans NUM_DIGITS digits, one slot of REFRESH_DIV clocks each. New display data
// is captured into a pending register on load and moved into the shadow register
// only at a frame boundary, so a frame is never torn. All display outputs are
// registered and lag the slot counters by one cycle.
//
// Optional feature macro: SEG7_DIM_EN
//   defined   - PWM dimming inside each slot, duty set by brightness
//               (sampled at the start of every slot).
//   undefined - brightness is ignored, no dimming logic is built.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       hex nibbles, digit k = value[4k+3:4k]
//   dp_in       decimal point per digit, 1 = lit
//   blank_in    per digit, 1 = dark
//   load        capture value/dp_in/blank_in into the pending register
//   enable      0 = display dark, counters and load path keep running
//   brightness  duty level (SEG7_DIM_EN only)
//   seg         {g,f,e,d,c,b,a}, active low
//   dp          decimal point, active low
//   an          digit anodes, active low
//   digit_idx   current slot index
//   frame_done  one-cycle pulse in the last cycle of every frame
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIM_BITS    = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [4*NUM_DIGITS-1:0]                           value,
    input  logic [NUM_DIGITS-1:0]                             dp_in,
    input  logic [NUM_DIGITS-1:0]                             blank_in,
    input  logic                                              load,
    input  logic                                              enable,
    input  logic [DIM_BITS-1:0]                               brightness,
    output logic [6:0]                                        seg,
    output logic                                              dp,
    output logic [NUM_DIGITS-1:0]                             an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                              frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic                    frame_done_q, frame_done_d;

    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_valid_q, pend_valid_d;

    logic [4*NUM_DIGITS-1:0] shad_val_q, shad_val_d;
    logic [NUM_DIGITS-1:0]   shad_dp_q, shad_dp_d;
    logic [NUM_DIGITS-1:0]   shad_blank_q, shad_blank_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic [3:0]              cur_nib;
    logic                    lit;

`ifdef SEG7_DIM_EN
    localparam int unsigned STEP = REFRESH_DIV >> DIM_BITS;
    logic [DIM_BITS-1:0] bright_q, bright_d;

    // Brightness only changes at slot starts so the duty of a slot is stable.
    always_comb begin
        bright_d = bright_q;
        if (div_cnt_q == '0) begin
            bright_d = brightness;
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
`endif

    // Slot / digit counters. frame_done is registered from the next state so it
    // is high exactly while the counters sit on the last cycle of the frame.
    always_comb begin
        div_cnt_d   = div_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (div_cnt_q == LAST_CNT) begin
            div_cnt_d   = '0;
            digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + IDX_W'(1);
        end
        frame_done_d = (div_cnt_d == LAST_CNT) && (digit_idx_d == LAST_IDX);
    end

    // Pending/shadow handoff. The boundary transfer reads the old pending value,
    // so a load on the boundary cycle lands in pending for the following frame.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        shad_val_d   = shad_val_q;
        shad_dp_d    = shad_dp_q;
        shad_blank_d = shad_blank_q;
        if (frame_done_q && pend_valid_q) begin
            shad_val_d   = pend_val_q;
            shad_dp_d    = pend_dp_q;
            shad_blank_d = pend_blank_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end
    end

    // Display decode. div_cnt == 0 is kept dark so the previous digit's
    // segments never bleed into the next anode while drivers switch.
    always_comb begin
        cur_nib = shad_val_q[{digit_idx_q, 2'b00} +: 4];
        lit     = enable && !shad_blank_q[digit_idx_q] && (div_cnt_q != '0);
`ifdef SEG7_DIM_EN
        lit     = lit && (32'(div_cnt_q) < STEP * (32'(bright_q) + 32'd1));
`endif
        an_d  = '1;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[digit_idx_q] = 1'b0;
            seg_d             = hex_to_seg(cur_nib);
            dp_d              = ~shad_dp_q[digit_idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            shad_val_q   <= '0;
            shad_dp_q    <= '0;
            shad_blank_q <= '0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
`ifdef SEG7_DIM_EN
            bright_q     <= '0;
`endif
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            frame_done_q <= frame_done_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            shad_val_q   <= shad_val_d;
            shad_dp_q    <= shad_dp_d;
            shad_blank_q <= shad_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
`ifdef SEG7_DIM_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int DB = 2;
    localparam int FR = N * RD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          load;
    logic          enable;
    logic [DB-1:0] brightness;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic [1:0]    digit_idx;
    logic          frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .DIM_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .enable    (enable),
        .brightness(brightness),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    // Reference model: elapsed cycles since reset plus pending/shadow contents.
    int          t;
    logic [15:0] p_val, s_val;
    logic [3:0]  p_dp, p_blank, s_dp, s_blank;
    bit          pv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        p_val = '0; p_dp = '0; p_blank = '0; pv = 1'b0;
        s_val = '0; s_dp = '0; s_blank = '0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus (called on a negedge) and queue the outputs
    // expected just after the following rising edge.
    task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] b, input logic en);
        exp_t e;
        int   cnt, slot;
        bit   lit;
        load = ld; value = v; dp_in = d; blank_in = b; enable = en;
        cnt  = t % RD;
        slot = (t / RD) % N;
        lit  = en && !s_blank[slot] && (cnt != 0);
        e.an  = lit ? ~(4'b0001 << slot) : 4'b1111;
        e.seg = lit ? SEG_TAB[s_val[slot*4 +: 4]] : 7'b1111111;
        e.dp  = lit ? ~s_dp[slot] : 1'b1;
        e.idx = 2'(((t + 1) / RD) % N);
        e.fd  = (((t + 1) % FR) == FR - 1);
        sb.push_back(e);
        if ((t % FR) == FR - 1 && pv) begin
            s_val = p_val; s_dp = p_dp; s_blank = p_blank; pv = 1'b0;
        end
        if (ld) begin
            p_val = v; p_dp = d; p_blank = b; pv = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), en);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"},  32'(dp), 32'h1);
        check({tag, "_fd"},  32'(frame_done), 32'h0);
        check({tag, "_idx"}, 32'(digit_idx), 32'h0);
    endtask

    always @(posedge clk) begin
        exp_t e, a;
        if (mon_on) begin
            #1;
            a = '{an, seg, dp, digit_idx, frame_done};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: output seen with nothing expected", $time);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL out at %0t: got an=%b seg=%b dp=%b idx=%0d fd=%b, expected an=%b seg=%b dp=%b idx=%0d fd=%b",
                             $time, a.an, a.seg, a.dp, a.idx, a.fd, e.an, e.seg, e.dp, e.idx, e.fd);
                end
            end
        end
    end

    initial begin
        load = 1'b0; value = '0; dp_in = '0; blank_in = '0; enable = 1'b0;
        brightness = '1;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_on = 1'b1;

        // Reset shadow: every digit shows "0".
        idle(2 * FR, 1'b1);

        // Load 1A2F with dp on digit 0.
        cyc(1'b1, 16'h1A2F, 4'b0001, 4'b0000, 1'b1);
        idle(3 * FR, 1'b1);

        // Reset mid-frame while a digit is lit.
        while ((t % RD) != 2) idle(1, 1'b1);
        mon_on = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_on = 1'b1;
        cyc(1'b1, 16'h1A2F, 4'b0001, 4'b0000, 1'b1);
        idle(2 * FR, 1'b1);

        // Two loads inside one frame (last wins), then a load on the boundary.
        while (((t / RD) % N) != 1) idle(1, 1'b1);
        cyc(1'b1, 16'h1111, 4'b0000, 4'b0000, 1'b1);
        while (((t / RD) % N) != 2) idle(1, 1'b1);
        cyc(1'b1, 16'h2222, 4'b0010, 4'b0000, 1'b1);
        while ((t % FR) != FR - 1) idle(1, 1'b1);
        cyc(1'b1, 16'h3333, 4'b0100, 4'b0000, 1'b1);
        idle(3 * FR, 1'b1);

        // Blank digit 2.
        cyc(1'b1, 16'hC0DE, 4'b1010, 4'b0100, 1'b1);
        idle(3 * FR, 1'b1);

        // Enable toggling mid-slot.
        for (int i = 0; i < 3 * FR; i++) idle(1, ((t % 7) < 3) ? 1'b0 : 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
                4'($urandom), ($urandom_range(0, 7) != 0));
        end

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
